// File: rtl/iram_bit.sv
// iram_bit: 8051 internal data RAM with byte access, bit-addressable window and post-reset clear.
// Latency: reads return data_out/bit_out with rd_valid one cycle after acceptance; bit writes cost one extra RMW cycle.
// Backpressure: ready=0 during clear and RMW; requests presented while ready=0 are dropped, not queued.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ram_en              request enable; accepted when ram_en & ready & (read_en | write_en)
//   read_en, write_en   request includes a read / a write
//   bit_mode            1: addr is a bit address into the bit-addressable region
//   addr                word or bit address
//   data_in, bit_in     write data for word / bit writes
//   data_out, bit_out   registered read word / bit, held until the next read completes
//   rd_valid            one-cycle pulse when data_out/bit_out are updated
//   ready               request can be accepted this cycle
//   addr_err            one-cycle pulse after an out-of-range request was accepted
module iram_bit #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 7,
  parameter int DEPTH      = 2**ADDR_W,
  parameter int BIT_BASE   = 'h20,
  parameter int BIT_WORDS  = 16,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_en,
  input  logic              read_en,
  input  logic              write_en,
  input  logic              bit_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data_out,
  output logic              bit_out,
  output logic              rd_valid,
  output logic              ready,
  output logic              addr_err
);

  localparam int BI_W  = $clog2(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_RMW  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  clr_cnt;
  logic [IDX_W-1:0]  rmw_word;
  logic [BI_W-1:0]   rmw_bit;
  logic              rmw_val;

  // Address decode. Bit-region arithmetic is done in 32 bits so that a large
  // bit address can never wrap back onto a valid word.
  logic [31:0]       bit_word_idx;
  logic [31:0]       bit_word;
  logic [ADDR_W-1:0] word_sel;
  logic [IDX_W-1:0]  mem_idx;
  logic [BI_W-1:0]   bit_sel;
  logic              in_range;
  logic              accept;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rmw_data;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd;

  always_comb begin
    bit_word_idx = 32'(addr) >> BI_W;
    bit_word     = 32'(BIT_BASE) + bit_word_idx;
    word_sel     = bit_mode ? bit_word[ADDR_W-1:0] : addr;
    mem_idx      = word_sel[IDX_W-1:0];
    bit_sel      = addr[BI_W-1:0];
    if (bit_mode) begin
      in_range = (bit_word_idx < 32'(BIT_WORDS)) && (bit_word < 32'(DEPTH));
    end else begin
      in_range = (32'(addr) < 32'(DEPTH));
    end
  end

  assign ready   = rst_n && (state == S_IDLE);
  assign accept  = ram_en && ready && (read_en || write_en);
  assign rd_word = mem[mem_idx];

  // Read-modify-write merge: the array cannot change during RMW (ready=0),
  // so re-reading the word here sees exactly what was there at acceptance.
  always_comb begin
    rmw_data          = mem[rmw_word];
    rmw_data[rmw_bit] = rmw_val;
  end

  // Single write port shared by clear, word write and RMW write-back.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = mem_idx;
    mem_wd = data_in;
    case (state)
      S_INIT: begin
        mem_we = rst_n;
        mem_wa = clr_cnt;
        mem_wd = '0;
      end
      S_IDLE: begin
        mem_we = accept && write_en && !bit_mode && in_range;
      end
      S_RMW: begin
        mem_we = rst_n;
        mem_wa = rmw_word;
        mem_wd = rmw_data;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (INIT_CLEAR != 0) begin
        state <= S_INIT;
      end else begin
        state <= S_IDLE;
      end
      clr_cnt  <= '0;
      rmw_word <= '0;
      rmw_bit  <= '0;
      rmw_val  <= 1'b0;
      data_out <= '0;
      bit_out  <= 1'b0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        S_INIT: begin
          // Counter parks on the last word; the state change ends the clear.
          if (clr_cnt == LAST_WORD) begin
            state <= S_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            if (!in_range) begin
              addr_err <= 1'b1;
              if (read_en) begin
                rd_valid <= 1'b1;
                data_out <= '0;
                bit_out  <= 1'b0;
              end
            end else if (bit_mode) begin
              // Read returns the pre-modify value (JBC read-then-clear).
              if (read_en) begin
                rd_valid <= 1'b1;
                data_out <= rd_word;
                bit_out  <= rd_word[bit_sel];
              end
              if (write_en) begin
                rmw_word <= mem_idx;
                rmw_bit  <= bit_sel;
                rmw_val  <= bit_in;
                state    <= S_RMW;
              end
            end else if (read_en) begin
              // Same-request write and read: write-first.
              rd_valid <= 1'b1;
              data_out <= write_en ? data_in : rd_word;
            end
          end
        end
        S_RMW: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iram_bit.sv
`timescale 1ns/1ps
module tb_iram_bit;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int DEP = 128;
  localparam int BB  = 'h20;
  localparam int BWN = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ram_en, read_en, write_en, bit_mode, bit_in;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          bit_out, rd_valid, ready, addr_err;

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    logic       b;
    logic       v;
    logic       e;
    int         due;
  } exp_t;

  exp_t q[$];

  // Reference model: plain array plus the held output values.
  logic [7:0] m_mem [DEP];
  bit         m_rmw;
  int         m_rw, m_rb;
  bit         m_rv;
  logic [7:0] m_dout;
  logic       m_bout;

  iram_bit #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP),
    .BIT_BASE(BB), .BIT_WORDS(BWN), .INIT_CLEAR(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ram_en(ram_en), .read_en(read_en),
    .write_en(write_en), .bit_mode(bit_mode), .addr(addr),
    .data_in(data_in), .bit_in(bit_in), .data_out(data_out),
    .bit_out(bit_out), .rd_valid(rd_valid), .ready(ready),
    .addr_err(addr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output pulse, and flags expectations
  // whose due cycle passes without a pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1 || addr_err === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: rd_valid=%b addr_err=%b data_out=%h bit_out=%b at edge %0d",
                   rd_valid, addr_err, data_out, bit_out, edges);
        end else begin
          e = q.pop_front();
          if (data_out !== e.d || bit_out !== e.b || rd_valid !== e.v ||
              addr_err !== e.e || edges != e.due) begin
            errors++;
            $display("FAIL response: got d=%h b=%b v=%b err=%b edge=%0d expected d=%h b=%b v=%b err=%b edge=%0d",
                     data_out, bit_out, rd_valid, addr_err, edges, e.d, e.b, e.v, e.e, e.due);
          end
        end
      end else if (q.size() > 0 && q[0].due <= edges) begin
        checks++;
        errors++;
        e = q.pop_front();
        $display("FAIL missing_output: expected d=%h b=%b v=%b err=%b at edge %0d, nothing seen",
                 e.d, e.b, e.v, e.e, e.due);
      end
    end
  end

  // One cycle of stimulus; updates the model and queues the expected response.
  task automatic drive(input bit en, input bit rd, input bit wr, input bit bm,
                       input logic [7:0] a, input logic [7:0] din, input bit bin);
    exp_t e;
    bit   acc, inr;
    int   idx, w, b;
    @(negedge clk);
    ram_en = en; read_en = rd; write_en = wr; bit_mode = bm;
    addr = a; data_in = din; bit_in = bin;
    chk("ready", ready, {31'd0, !m_rmw});
    acc = en && (rd || wr) && !m_rmw;
    if (m_rmw) begin
      m_mem[m_rw][m_rb] = m_rv;
      m_rmw = 1'b0;
    end
    if (acc) begin
      b = a % 8;
      if (bm) begin
        idx = a / 8;
        w   = BB + idx;
        inr = (idx < BWN) && (w < DEP);
      end else begin
        w   = a;
        inr = (a < DEP);
      end
      if (!inr) begin
        if (rd) begin
          m_dout = '0;
          m_bout = 1'b0;
        end
        e = '{m_dout, m_bout, rd, 1'b1, edges + 1};
        q.push_back(e);
      end else if (bm) begin
        if (rd) begin
          m_dout = m_mem[w];
          m_bout = m_mem[w][b];
          e = '{m_dout, m_bout, 1'b1, 1'b0, edges + 1};
          q.push_back(e);
        end
        if (wr) begin
          m_rmw = 1'b1;
          m_rw  = w;
          m_rb  = b;
          m_rv  = bin;
        end
      end else begin
        if (wr) m_mem[w] = din;
        if (rd) begin
          m_dout = m_mem[w];
          e = '{m_dout, m_bout, 1'b1, 1'b0, edges + 1};
          q.push_back(e);
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic reset_and_init(input string tag);
    int n;
    rst_n = 1'b0;
    ram_en = 0; read_en = 0; write_en = 0; bit_mode = 0;
    addr = '0; data_in = '0; bit_in = 0;
    repeat (3) @(negedge clk);
    chk({tag, "_rst_data_out"}, data_out, 0);
    chk({tag, "_rst_bit_out"}, bit_out, 0);
    chk({tag, "_rst_rd_valid"}, rd_valid, 0);
    chk({tag, "_rst_addr_err"}, addr_err, 0);
    chk({tag, "_rst_ready"}, ready, 0);
    rst_n = 1'b1;
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (ready === 1'b1) break;
    end
    chk({tag, "_init_edges"}, n, DEP);
    for (int i = 0; i < DEP; i++) m_mem[i] = '0;
    m_rmw  = 1'b0;
    m_dout = '0;
    m_bout = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit bm;
    reset_and_init("boot");

    // Cleared array, then word access and write-first.
    drive(1, 1, 0, 0, 8'h7F, 8'h00, 0);
    drive(1, 0, 1, 0, 8'h10, 8'hA5, 0);
    drive(1, 1, 0, 0, 8'h10, 8'h00, 0);
    drive(1, 1, 1, 0, 8'h11, 8'h3C, 0);
    drive(1, 1, 0, 0, 8'h11, 8'h00, 0);

    // Bit write into word 0x21 bit 3, request during RMW is dropped.
    drive(1, 0, 1, 1, 8'h0B, 8'h00, 1);
    drive(1, 1, 0, 0, 8'h21, 8'h00, 0);
    drive(1, 1, 0, 0, 8'h21, 8'h00, 0);
    drive(1, 1, 0, 1, 8'h0B, 8'h00, 0);

    // Read-then-clear on word 0x20 bit 0.
    drive(1, 0, 1, 0, 8'h20, 8'hFF, 0);
    drive(1, 1, 1, 1, 8'h00, 8'h00, 0);
    drive(1, 1, 0, 0, 8'h30, 8'h00, 0);
    drive(1, 1, 0, 0, 8'h20, 8'h00, 0);

    // Top of the bit region and range errors; 0x90 must not alias onto 0x10.
    drive(1, 1, 1, 1, 8'h7F, 8'h00, 1);
    drive(1, 1, 0, 0, 8'h2F, 8'h00, 0);
    drive(1, 1, 0, 1, 8'h80, 8'h00, 0);
    drive(1, 0, 1, 1, 8'h80, 8'h00, 1);
    drive(1, 0, 1, 0, 8'h90, 8'h77, 0);
    drive(1, 1, 0, 0, 8'h90, 8'h00, 0);
    drive(1, 1, 0, 0, 8'h10, 8'h00, 0);
    drive(0, 1, 1, 0, 8'h10, 8'h00, 0);

    // Randomized traffic.
    for (int i = 0; i < 700; i++) begin
      bm = ($urandom_range(0, 9) < 3);
      drive($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            bm, 8'($urandom_range(0, bm ? 159 : 143)), 8'($urandom), 1'($urandom));
    end

    // Reset in the middle of an RMW.
    drive(1, 0, 1, 0, 8'h30, 8'h5A, 0);
    drive(1, 1, 0, 0, 8'h30, 8'h00, 0);
    drive(1, 0, 1, 1, 8'h11, 8'h00, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrmw_data_out", data_out, 0);
    chk("midrmw_bit_out", bit_out, 0);
    chk("midrmw_rd_valid", rd_valid, 0);
    chk("midrmw_ready", ready, 0);
    chk("midrmw_queue_empty", q.size(), 0);
    q.delete();
    reset_and_init("rmw");
    drive(1, 1, 0, 0, 8'h22, 8'h00, 0);
    drive(1, 1, 0, 1, 8'h11, 8'h00, 0);
    drive(1, 1, 0, 0, 8'h10, 8'h00, 0);

    repeat (4) drive(0, 0, 0, 0, 8'h00, 8'h00, 0);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
